mem_responder: RTL and testbench
================================

# mem_responder

Responder end of the CPU memory request protocol. It accepts instruction-fetch requests (iREN) and data requests (dREN/dWEN) from the request unit and datapath, and arbitrates them onto a single variable-latency RAM port. It returns one-cycle ihit/dhit pulses with registered load data. It sits between the CPU core and the RAM model and is the block that produces the ihit/dhit that gate PC advance and the clearing of data requests.

## Interface
Parameters:
- TIMEOUT, default 255: cycles a granted access may wait for RAM before it is aborted; legal range 1..1023.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  1  instruction read request; level, held until ihit.
- iaddr  in  32  instruction word address.
- dREN  in  1  data read request; level, held until dhit.
- dWEN  in  1  data write request; level, held until dhit.
- daddr  in  32  data address.
- dstore  in  32  write data.
- ihit  out  1  one-cycle pulse: instruction access complete.
- iload  out  32  fetched instruction; valid while ihit=1, holds value otherwise.
- dhit  out  1  one-cycle pulse: data access complete.
- dload  out  32  read data; valid while dhit=1 after a read, holds value otherwise.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data; valid when ramstate=ACCESS.
- ramstate  in  2  00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR.
- err  out  1  sticky error flag; cleared only by RST.

## Operation
- States: IDLE, IACC, DACC, TURN.
- IDLE:
  - If dREN|dWEN, latch daddr/dstore/op and go to DACC.
  - Else, if iREN, latch iaddr and go to IACC.
  - Data has priority, except one fairness rule: if the previous completed access was data and iREN=1, grant I first.
- dREN=dWEN=1 simultaneously: treated as a write and err is set; the access proceeds.
- IACC/DACC:
  - ramREN (or ramWEN) is high and ramaddr/ramstore come from the latched request, not the live inputs.
  - Input changes during an access are ignored.
- Completion occurs on a cycle where ramstate=ACCESS. At that edge:
  - Register ramload into iload (IACC) or into dload (DACC read). dload is unchanged on a write.
  - Pulse ihit or dhit.
  - Go to TURN.
- ramstate=ERROR, or the wait counter reaching TIMEOUT:
  - Abort and set err.
  - Still pulse the hit, with load = 32'hBAD1BAD1, so the core never deadlocks.
  - Go to TURN.
- TURN (the hit cycle):
  - ramREN=ramWEN=0.
  - Go to IDLE unconditionally. Requests are not sampled in TURN.
- Wait counter is 10 bits:
  - Cleared on entry to IACC/DACC.
  - Increments each cycle ramstate is FREE or BUSY.
  - Compared with TIMEOUT using ==. It never wraps.
- Reset values (any cycle RST=1):
  - State IDLE.
  - ihit, dhit, ramREN, ramWEN, err = 0.
  - iload, dload, ramaddr, ramstore = 0.
  - Counter 0; fairness bit 0.
- Reset mid-access abandons the access; no hit is produced for it.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Request high in IDLE at cycle 0 → ram strobe and address valid from cycle 1.
- ramstate=ACCESS in cycle k (k≥1) → hit=1 and load valid in cycle k+1 → IDLE in cycle k+2.
- Minimum request-to-hit latency is 2 cycles. Back-to-back accesses start at most every 3 cycles.
- Hit is exactly one cycle wide, and the strobes are low during it (one dead cycle between RAM accesses).
- The requester drops its request on the hit edge, so the request is already low when IDLE samples again.
- Timeout: with ramstate stuck BUSY, the abort hit appears TIMEOUT+2 cycles after the request.

## Test plan
- Reset: hold RST=1 with iREN=dREN=1 and ramstate=ACCESS → all outputs 0 and no hit; release RST → IACC/DACC is entered per the priority rules.
- Instruction read: iREN=1, iaddr=0x40; ramstate=BUSY for 3 cycles then ACCESS with ramload=0x8C010004 → ramaddr=0x40 from cycle 1, ihit in cycle 5, iload=0x8C010004, dhit stays 0.
- Data write: dWEN=1, daddr=0x100, dstore=0xDEADBEEF; ramstate=ACCESS at cycle 1 → ramWEN=1 and ramstore=0xDEADBEEF in cycle 1, dhit in cycle 2, dload unchanged.
- Arbitration: iREN=dREN=1 held from cycle 0, RAM always ACCESS → data completes first (dhit in cycle 2), then instruction (ihit in cycle 5) even though dREN is reasserted; no overlapping strobes.
- Error/timeout, TIMEOUT=4:
  - ramstate stuck BUSY → ihit in cycle 6, iload=0xBAD1BAD1, err=1 and stays set.
  - ramstate=ERROR → same abort behaviour.
- Mid-access change: change daddr from 0x100 to 0x200 during DACC → ramaddr stays 0x100 until dhit.

Source files
------------

// File: rtl/mem_responder.sv
// Purpose: arbitrates CPU instruction-fetch and data requests onto one variable-latency RAM port.
// Latency: strobe in the cycle after the request; hit one cycle after RAM reports ACCESS (minimum 2 cycles).
// Backpressure: requests are held as levels until the hit; RAM BUSY/FREE stalls, ERROR or timeout aborts.
module mem_responder #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    TURN = 2'd3
  } state_t;

  localparam logic [1:0]  RS_ACCESS   = 2'b10;
  localparam logic [1:0]  RS_ERROR    = 2'b11;
  localparam logic [9:0]  TIMEOUT_CNT = 10'(TIMEOUT);
  localparam logic [31:0] ABORT_WORD  = 32'hBAD1_BAD1;

  state_t      r_state;
  logic [9:0]  r_cnt;
  logic        r_last_d;   // last completed access was a data access
  logic        r_is_wr;    // latched data op is a write
  logic        r_ihit;
  logic        r_dhit;
  logic [31:0] r_iload;
  logic [31:0] r_dload;
  logic        r_ramREN;
  logic        r_ramWEN;
  logic [31:0] r_ramaddr;
  logic [31:0] r_ramstore;
  logic        r_err;

  logic        w_dreq;
  logic        w_grant_d;
  logic        w_grant_i;
  logic        w_wait;
  logic        w_done;
  logic        w_abort;

  // Arbitration and completion decode. FREE/BUSY both mean "still waiting" (ramstate[1]=0).
  always_comb begin
    w_dreq    = dREN | dWEN;
    w_grant_d = w_dreq & ~(r_last_d & iREN);
    w_grant_i = iREN & ~w_grant_d;
    w_wait    = ~ramstate[1];
    w_done    = (ramstate == RS_ACCESS);
    w_abort   = (ramstate == RS_ERROR) | (w_wait & (r_cnt == TIMEOUT_CNT));
  end

  // Access FSM with fully registered outputs; the hit cycle is TURN, where strobes are low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_last_d   <= 1'b0;
      r_is_wr    <= 1'b0;
      r_ihit     <= 1'b0;
      r_dhit     <= 1'b0;
      r_iload    <= '0;
      r_dload    <= '0;
      r_ramREN   <= 1'b0;
      r_ramWEN   <= 1'b0;
      r_ramaddr  <= '0;
      r_ramstore <= '0;
      r_err      <= 1'b0;
    end else begin
      r_ihit <= 1'b0;
      r_dhit <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state    <= DACC;
            r_cnt      <= '0;
            r_ramaddr  <= daddr;
            r_ramstore <= dstore;
            // A simultaneous read+write is executed as a write and flagged.
            r_is_wr    <= dWEN;
            r_ramWEN   <= dWEN;
            r_ramREN   <= ~dWEN;
            if (dREN & dWEN) begin
              r_err <= 1'b1;
            end
          end else if (w_grant_i) begin
            r_state   <= IACC;
            r_cnt     <= '0;
            r_ramaddr <= iaddr;
            r_ramREN  <= 1'b1;
            r_ramWEN  <= 1'b0;
          end
        end
        IACC, DACC: begin
          if (w_abort || w_done) begin
            r_state  <= TURN;
            r_ramREN <= 1'b0;
            r_ramWEN <= 1'b0;
            if (w_abort) begin
              r_err <= 1'b1;
            end
            if (r_state == IACC) begin
              r_ihit   <= 1'b1;
              r_iload  <= w_abort ? ABORT_WORD : ramload;
              r_last_d <= 1'b0;
            end else begin
              r_dhit   <= 1'b1;
              r_last_d <= 1'b1;
              // Writes leave the last read value in place.
              if (!r_is_wr) begin
                r_dload <= w_abort ? ABORT_WORD : ramload;
              end
            end
          end else if (w_wait) begin
            // Abort fires at TIMEOUT_CNT, so the counter stops before it could wrap.
            r_cnt <= r_cnt + 10'd1;
          end
        end
        TURN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ihit     = r_ihit;
  assign dhit     = r_dhit;
  assign iload    = r_iload;
  assign dload    = r_dload;
  assign ramREN   = r_ramREN;
  assign ramWEN   = r_ramWEN;
  assign ramaddr  = r_ramaddr;
  assign ramstore = r_ramstore;
  assign err      = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Purpose: self-checking bench for mem_responder using a hit scoreboard.
// Latency: expected hits carry the absolute cycle they must appear in.
// Backpressure: RAM state is scripted per test (ACCESS, BUSY, ERROR).
module tb_mem_responder;

  localparam logic [1:0] FREE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;
  localparam logic [1:0] ERROR  = 2'b11;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        ihit, dhit;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
  logic        err;

  typedef struct {
    bit          is_d;
    logic [31:0] load;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   c0;

  mem_responder #(.TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input bit is_d, input logic [31:0] load, input int at);
    exp_t e;
    e.is_d = is_d;
    e.load = load;
    e.cyc  = at;
    sb_q.push_back(e);
  endtask

  // Scoreboard: every hit must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (ihit || dhit) begin
      exp_t e;
      chk_eq("hit_overlap", 32'(ihit & dhit), 32'd0);
      chk_eq("hit_expected", 32'(sb_q.size() != 0), 32'd1);
      chk_eq("hit_strobes", 32'({ramREN, ramWEN}), 32'd0);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk_eq("hit_kind", 32'(dhit), 32'(e.is_d));
        chk_eq("hit_cycle", cyc, e.cyc);
        chk_eq("hit_load", dhit ? dload : iload, e.load);
      end
    end
    if (ramREN && ramWEN) begin
      chk_eq("strobe_overlap", 32'(ramREN & ramWEN), 32'd0);
    end
  end

  task automatic end_test(input string tag);
    chk_eq(tag, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  // Leaves the bench in cycle 0: RST just dropped, outputs still in reset state.
  task automatic do_reset();
    RST = 1'b1;
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0;
    ramload = 0; ramstate = FREE;
    tick(); tick();
    RST = 1'b0;
  endtask

  initial begin
    // Reset with live requests and RAM ACCESS: nothing may escape.
    RST = 1'b1;
    iREN = 1; dREN = 1; dWEN = 0;
    iaddr = 32'h44; daddr = 32'h300; dstore = 32'h0;
    ramstate = ACCESS; ramload = 32'h1111_1111;
    tick(); tick(); tick();
    chk_eq("rst_ihit", 32'(ihit), 32'd0);
    chk_eq("rst_dhit", 32'(dhit), 32'd0);
    chk_eq("rst_ramREN", 32'(ramREN), 32'd0);
    chk_eq("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk_eq("rst_err", 32'(err), 32'd0);
    chk_eq("rst_iload", iload, 32'd0);
    chk_eq("rst_dload", dload, 32'd0);
    chk_eq("rst_ramaddr", ramaddr, 32'd0);
    chk_eq("rst_ramstore", ramstore, 32'd0);

    // Arbitration: data first, then fairness grants I, then data again.
    RST = 1'b0;
    c0 = cyc;
    push_exp(1'b1, 32'h1111_1111, c0 + 2);
    push_exp(1'b0, 32'h2222_2222, c0 + 5);
    tick();                                   // c1
    chk_eq("arb_d_ramREN", 32'(ramREN), 32'd1);
    chk_eq("arb_d_ramWEN", 32'(ramWEN), 32'd0);
    chk_eq("arb_d_ramaddr", ramaddr, 32'h300);
    tick();                                   // c2: dhit
    dREN = 0;
    ramload = 32'h2222_2222;
    tick();                                   // c3: IDLE, reassert data
    dREN = 1;
    push_exp(1'b1, 32'h3333_3333, c0 + 8);
    tick();                                   // c4
    chk_eq("arb_i_ramaddr", ramaddr, 32'h44);
    chk_eq("arb_i_ramREN", 32'(ramREN), 32'd1);
    tick();                                   // c5: ihit
    iREN = 0;
    ramload = 32'h3333_3333;
    tick();                                   // c6
    tick();                                   // c7
    chk_eq("arb_d2_ramaddr", ramaddr, 32'h300);
    tick();                                   // c8: dhit
    dREN = 0;
    tick(); tick();
    end_test("arb_done");

    // Instruction read with three BUSY cycles.
    do_reset();
    c0 = cyc;
    iREN = 1; iaddr = 32'h40; ramstate = BUSY;
    push_exp(1'b0, 32'h8C01_0004, c0 + 5);
    tick();                                   // c1
    chk_eq("ird_ramREN", 32'(ramREN), 32'd1);
    chk_eq("ird_ramaddr", ramaddr, 32'h40);
    tick(); tick(); tick();                   // c4
    ramstate = ACCESS; ramload = 32'h8C01_0004;
    tick();                                   // c5: ihit
    iREN = 0; ramstate = FREE;
    tick(); tick();
    chk_eq("ird_err", 32'(err), 32'd0);
    end_test("ird_done");

    // Data write: dload must keep its old value.
    do_reset();
    c0 = cyc;
    dWEN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
    ramstate = ACCESS; ramload = 32'h5555_5555;
    push_exp(1'b1, 32'h0, c0 + 2);
    tick();                                   // c1
    chk_eq("wr_ramWEN", 32'(ramWEN), 32'd1);
    chk_eq("wr_ramREN", 32'(ramREN), 32'd0);
    chk_eq("wr_ramstore", ramstore, 32'hDEAD_BEEF);
    chk_eq("wr_ramaddr", ramaddr, 32'h100);
    tick();                                   // c2: dhit
    dWEN = 0;
    tick(); tick();
    end_test("wr_done");

    // Inputs changing mid-access are ignored.
    do_reset();
    c0 = cyc;
    dREN = 1; daddr = 32'h100; ramstate = BUSY;
    push_exp(1'b1, 32'h7777_7777, c0 + 4);
    tick();                                   // c1
    daddr = 32'h200; dWEN = 1; dstore = 32'h1234_5678;
    tick();                                   // c2
    chk_eq("mid_ramaddr_c2", ramaddr, 32'h100);
    tick();                                   // c3
    ramstate = ACCESS; ramload = 32'h7777_7777;
    chk_eq("mid_ramaddr_c3", ramaddr, 32'h100);
    chk_eq("mid_ramWEN", 32'(ramWEN), 32'd0);
    tick();                                   // c4: dhit
    dREN = 0; dWEN = 0; ramstate = FREE;
    chk_eq("mid_err", 32'(err), 32'd0);
    tick(); tick();
    end_test("mid_done");

    // Read+write together: performed as a write, err set.
    do_reset();
    c0 = cyc;
    dREN = 1; dWEN = 1; daddr = 32'h20; dstore = 32'hCAFE_F00D;
    ramstate = ACCESS; ramload = 32'h9999_9999;
    push_exp(1'b1, 32'h0, c0 + 2);
    tick();                                   // c1
    chk_eq("rw_ramWEN", 32'(ramWEN), 32'd1);
    chk_eq("rw_ramREN", 32'(ramREN), 32'd0);
    tick();                                   // c2: dhit
    dREN = 0; dWEN = 0;
    chk_eq("rw_err", 32'(err), 32'd1);
    tick(); tick();
    end_test("rw_done");

    // Timeout with RAM stuck BUSY (TIMEOUT=4): abort hit at cycle 6.
    do_reset();
    chk_eq("rst_clears_err", 32'(err), 32'd0);
    c0 = cyc;
    iREN = 1; iaddr = 32'h80; ramstate = BUSY; ramload = 32'h1234_5678;
    push_exp(1'b0, 32'hBAD1_BAD1, c0 + 6);
    tick(); tick(); tick(); tick(); tick();   // c5
    chk_eq("to_err_pre", 32'(err), 32'd0);
    tick();                                   // c6: abort ihit
    iREN = 0;
    chk_eq("to_err", 32'(err), 32'd1);
    tick(); tick(); tick();
    chk_eq("to_err_sticky", 32'(err), 32'd1);
    chk_eq("to_ramREN", 32'(ramREN), 32'd0);
    end_test("to_done");

    // RAM ERROR aborts a data read.
    do_reset();
    c0 = cyc;
    dREN = 1; daddr = 32'h10; ramstate = BUSY; ramload = 32'h4444_4444;
    push_exp(1'b1, 32'hBAD1_BAD1, c0 + 3);
    tick();                                   // c1
    tick();                                   // c2
    ramstate = ERROR;
    tick();                                   // c3: abort dhit
    dREN = 0; ramstate = FREE;
    chk_eq("er_err", 32'(err), 32'd1);
    tick(); tick();
    end_test("er_done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
